// File: rtl/iir_pkg.sv
// Shared types and default sizing for the IIR filter sequencer and its coefficient bank.
package iir_pkg;

    localparam int DEF_SIGNAL_BITS    = 24;
    localparam int DEF_COEFF_BITS     = 18;
    localparam int DEF_COEFF_LENGTH   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef logic signed [DEF_COEFF_BITS-1:0]  coeff_t;
    typedef logic signed [DEF_SIGNAL_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } seq_state_e;

endpackage

// File: rtl/iir_coeff_bank.sv
// Double-buffered coefficient storage: register-port writes land in shadow, a commit
// copies shadow to active only when the sequencer says it is between samples.
module iir_coeff_bank
    import iir_pkg::*;
#(
    parameter int COEFF_LENGTH = DEF_COEFF_LENGTH,
    parameter int COEFF_BITS   = DEF_COEFF_BITS,
    parameter int IDX_BITS     = (COEFF_LENGTH > 1) ? $clog2(COEFF_LENGTH) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   coeff_wr_i,
    input  logic                                   coeff_den_i,
    input  logic [IDX_BITS-1:0]                    coeff_idx_i,
    input  logic [COEFF_BITS-1:0]                  coeff_data_i,
    input  logic                                   coeff_commit_i,
    input  logic                                   swap_en_i,
    output logic                                   commit_pending_o,
    output logic [COEFF_LENGTH-1:0][COEFF_BITS-1:0] num_o,
    output logic [COEFF_LENGTH-1:0][COEFF_BITS-1:0] den_o
);

    typedef logic [COEFF_LENGTH-1:0][COEFF_BITS-1:0] bank_t;

    bank_t sh_num_q, sh_num_d;
    bank_t sh_den_q, sh_den_d;
    bank_t act_num_q, act_num_d;
    bank_t act_den_q, act_den_d;
    logic  pending_q, pending_d;
    logic  swap;

    // A commit arriving on a swap-eligible cycle is applied at once.
    assign swap = swap_en_i & (pending_q | coeff_commit_i);

    // Indices with no matching tap simply fall through and are dropped.
    always_comb begin
        sh_num_d = sh_num_q;
        sh_den_d = sh_den_q;
        for (int t = 0; t < COEFF_LENGTH; t++) begin
            if (coeff_wr_i && (coeff_idx_i == IDX_BITS'(t))) begin
                if (coeff_den_i) sh_den_d[t] = coeff_data_i;
                else             sh_num_d[t] = coeff_data_i;
            end
        end
    end

    // Swap copies the post-write shadow so a same-cycle write is included.
    always_comb begin
        act_num_d = act_num_q;
        act_den_d = act_den_q;
        if (swap) begin
            act_num_d = sh_num_d;
            act_den_d = sh_den_d;
        end
        pending_d = (pending_q | coeff_commit_i) & ~swap;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sh_num_q  <= '0;
            sh_den_q  <= '0;
            act_num_q <= '0;
            act_den_q <= '0;
            pending_q <= 1'b0;
        end else begin
            sh_num_q  <= sh_num_d;
            sh_den_q  <= sh_den_d;
            act_num_q <= act_num_d;
            act_den_q <= act_den_d;
            pending_q <= pending_d;
        end
    end

    assign commit_pending_o = pending_q;
    assign num_o            = act_num_q;
    assign den_o            = act_den_q;

endmodule

// File: rtl/iir_filter_sequencer.sv
// Drives one IIR filter per sample: accept, pulse start, wait for done (with timeout),
// hold the result until taken. Coefficient banks only swap between samples.
module iir_filter_sequencer
    import iir_pkg::*;
#(
    parameter int COEFF_LENGTH   = DEF_COEFF_LENGTH,
    parameter int SIGNAL_BITS    = DEF_SIGNAL_BITS,
    parameter int COEFF_BITS     = DEF_COEFF_BITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    sample_valid_i,
    output logic                                    sample_ready_o,
    input  logic signed [SIGNAL_BITS-1:0]           sample_i,
    output logic                                    result_valid_o,
    input  logic                                    result_ready_i,
    output logic signed [SIGNAL_BITS-1:0]           result_o,
    input  logic                                    coeff_wr_i,
    input  logic                                    coeff_den_i,
    input  logic [$clog2(COEFF_LENGTH)-1:0]         coeff_idx_i,
    input  logic signed [COEFF_BITS-1:0]            coeff_data_i,
    input  logic                                    coeff_commit_i,
    output logic                                    commit_pending_o,
    output logic                                    filt_start_o,
    output logic signed [SIGNAL_BITS-1:0]           filt_signal_o,
    input  logic                                    filt_done_i,
    input  logic signed [SIGNAL_BITS-1:0]           filt_signal_i,
    output logic [COEFF_LENGTH-1:0][COEFF_BITS-1:0] numerator_coeffs_o,
    output logic [COEFF_LENGTH-1:0][COEFF_BITS-1:0] denominator_coeffs_o,
    output logic                                    timeout_o
);

    localparam int TMR_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    seq_state_e             state_q;
    logic                   ready_q;
    logic                   valid_q;
    logic                   start_q;
    logic                   timeout_q;
    logic [SIGNAL_BITS-1:0] result_q;
    logic [SIGNAL_BITS-1:0] sig_q;
    logic [TMR_BITS-1:0]    timer_q;
    logic                   accept;
    logic                   swap_en;

    // A pending commit blocks acceptance for one IDLE cycle so the swap goes first.
    assign sample_ready_o = ready_q & ~commit_pending_o;
    assign accept         = sample_valid_i & sample_ready_o;
    assign swap_en        = ((state_q == IDLE) && !accept) ||
                            ((state_q == HOLD) && result_ready_i);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            sig_q     <= '0;
            timer_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        sig_q   <= sample_i;
                        start_q <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (filt_done_i) begin
                        result_q <= filt_signal_i;
                        valid_q  <= 1'b1;
                        state_q  <= HOLD;
                    end else if (timer_q == TMR_BITS'(TIMEOUT_CYCLES - 1)) begin
                        // Abort with a zero result so the stream keeps flowing.
                        timeout_q <= 1'b1;
                        result_q  <= '0;
                        valid_q   <= 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        timer_q <= timer_q + TMR_BITS'(1);
                    end
                end
                HOLD: begin
                    if (result_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    iir_coeff_bank #(
        .COEFF_LENGTH (COEFF_LENGTH),
        .COEFF_BITS   (COEFF_BITS),
        .IDX_BITS     ($clog2(COEFF_LENGTH))
    ) u_bank (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .coeff_wr_i       (coeff_wr_i),
        .coeff_den_i      (coeff_den_i),
        .coeff_idx_i      (coeff_idx_i),
        .coeff_data_i     (coeff_data_i),
        .coeff_commit_i   (coeff_commit_i),
        .swap_en_i        (swap_en),
        .commit_pending_o (commit_pending_o),
        .num_o            (numerator_coeffs_o),
        .den_o            (denominator_coeffs_o)
    );

    assign result_valid_o = valid_q;
    assign result_o       = result_q;
    assign filt_start_o   = start_q;
    assign filt_signal_o  = sig_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_iir_filter_sequencer.sv
// Scoreboard bench: a stub filter answers start pulses, a reference FIR model predicts results.
module tb_iir_filter_sequencer;

    localparam int CL = 4;
    localparam int SB = 24;
    localparam int CB = 18;
    localparam int TO = 64;

    logic                       clk_i = 1'b0;
    logic                       reset_i;
    logic                       sample_valid_i;
    logic                       sample_ready_o;
    logic signed [SB-1:0]       sample_i;
    logic                       result_valid_o;
    logic                       result_ready_i;
    logic signed [SB-1:0]       result_o;
    logic                       coeff_wr_i;
    logic                       coeff_den_i;
    logic [1:0]                 coeff_idx_i;
    logic signed [CB-1:0]       coeff_data_i;
    logic                       coeff_commit_i;
    logic                       commit_pending_o;
    logic                       filt_start_o;
    logic signed [SB-1:0]       filt_signal_o;
    logic                       filt_done_i;
    logic signed [SB-1:0]       filt_signal_i;
    logic [CL-1:0][CB-1:0]      numerator_coeffs_o;
    logic [CL-1:0][CB-1:0]      denominator_coeffs_o;
    logic                       timeout_o;

    always #5 clk_i = ~clk_i;

    iir_filter_sequencer #(
        .COEFF_LENGTH(CL), .SIGNAL_BITS(SB), .COEFF_BITS(CB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o), .sample_i(sample_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_o(result_o),
        .coeff_wr_i(coeff_wr_i), .coeff_den_i(coeff_den_i), .coeff_idx_i(coeff_idx_i),
        .coeff_data_i(coeff_data_i), .coeff_commit_i(coeff_commit_i),
        .commit_pending_o(commit_pending_o),
        .filt_start_o(filt_start_o), .filt_signal_o(filt_signal_o),
        .filt_done_i(filt_done_i), .filt_signal_i(filt_signal_i),
        .numerator_coeffs_o(numerator_coeffs_o), .denominator_coeffs_o(denominator_coeffs_o),
        .timeout_o(timeout_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [SB-1:0] sb_q[$];
    int mdl_num[CL], mdl_den[CL], sh_num[CL], sh_den[CL];
    int mdl_hist[$], stub_hist[$];
    bit stub_hang = 1'b0;
    int start_cnt = 0, start_run = 0, start_max = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_bank(input string name, input logic [CL-1:0][CB-1:0] bank, input int exp[CL]);
        for (int k = 0; k < CL; k++)
            chk($sformatf("%s[%0d]", name, k), longint'($signed(bank[k])), longint'(exp[k]));
    endtask

    // Q16 numerator-only response over the most recent samples (h[0] newest).
    function automatic logic signed [SB-1:0] fir(input int b[CL], input int h[$]);
        longint acc = 0;
        for (int k = 0; k < CL; k++)
            if (k < h.size()) acc += longint'(b[k]) * longint'(h[k]);
        return SB'(acc >>> 16);
    endfunction

    // Stub filter: uses the DUT's active bank, answers 1..5 cycles into WAIT.
    initial begin
        int b[CL];
        int lat;
        logic signed [SB-1:0] y;
        filt_done_i = 1'b0;
        filt_signal_i = '0;
        forever begin
            @(negedge clk_i);
            if (filt_start_o && !stub_hang) begin
                for (int k = 0; k < CL; k++) b[k] = int'($signed(numerator_coeffs_o[k]));
                stub_hist.push_front(int'(filt_signal_o));
                if (stub_hist.size() > CL) void'(stub_hist.pop_back());
                y = fir(b, stub_hist);
                lat = $urandom_range(1, 5);
                repeat (lat) @(negedge clk_i);
                filt_signal_i = y;
                filt_done_i = 1'b1;
                @(negedge clk_i);
                filt_done_i = 1'b0;
                filt_signal_i = SB'($urandom);
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (filt_start_o) begin
            start_run++;
            if (start_run == 1) start_cnt++;
            if (start_run > start_max) start_max = start_run;
        end else begin
            start_run = 0;
        end
    end

    // Monitor: pop and compare on every accepted result.
    initial forever begin
        @(negedge clk_i);
        if (reset_i && result_valid_o && result_ready_i) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL result_unexpected: got %0d, want none", result_o);
            end else begin
                chk("result", longint'(result_o), longint'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int x, input bit hang);
        int t = 0;
        stub_hang = hang;
        sample_i = SB'(x);
        sample_valid_i = 1'b1;
        while (!sample_ready_o && t < 300) begin tick(); t++; end
        chk("send_ready", longint'(sample_ready_o), 1);
        if (!sample_ready_o) begin sample_valid_i = 1'b0; return; end
        if (hang) begin
            sb_q.push_back('0);
        end else begin
            mdl_hist.push_front(x);
            if (mdl_hist.size() > CL) void'(mdl_hist.pop_back());
            sb_q.push_back(fir(mdl_num, mdl_hist));
        end
        tick();
        sample_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb_q.size() != 0 || result_valid_o) && t < 500) begin tick(); t++; end
        chk("drain", longint'(sb_q.size()), 0);
    endtask

    task automatic wr(input bit den, input int idx, input int data, input bit commit);
        coeff_wr_i = 1'b1;
        coeff_den_i = den;
        coeff_idx_i = 2'(idx);
        coeff_data_i = CB'(data);
        coeff_commit_i = commit;
        tick();
        coeff_wr_i = 1'b0;
        coeff_commit_i = 1'b0;
        if (den) sh_den[idx] = data; else sh_num[idx] = data;
        if (commit) begin mdl_num = sh_num; mdl_den = sh_den; end
    endtask

    // Three plain writes then the last tap together with the commit.
    task automatic load_num(input int b0, input int b1, input int b2, input int b3);
        wr(1'b0, 0, b0, 1'b0);
        wr(1'b0, 1, b1, 1'b0);
        wr(1'b0, 2, b2, 1'b0);
        wr(1'b0, 3, b3, 1'b1);
        chk_bank("num_loaded", numerator_coeffs_o, mdl_num);
        chk("pending_after_load", longint'(commit_pending_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic signed [SB-1:0] r;
        int sc;
        logic signed [SB-1:0] rs;

        for (int k = 0; k < CL; k++) begin mdl_num[k] = 0; mdl_den[k] = 0; sh_num[k] = 0; sh_den[k] = 0; end
        reset_i = 1'b1;
        sample_valid_i = 1'b0; sample_i = '0; result_ready_i = 1'b1;
        coeff_wr_i = 1'b0; coeff_den_i = 1'b0; coeff_idx_i = '0; coeff_data_i = '0; coeff_commit_i = 1'b0;
        #1 reset_i = 1'b0;
        #1;
        chk("rst_valid", longint'(result_valid_o), 0);
        chk("rst_result", longint'(result_o), 0);
        chk("rst_start", longint'(filt_start_o), 0);
        chk("rst_filt_sig", longint'(filt_signal_o), 0);
        chk("rst_pending", longint'(commit_pending_o), 0);
        chk("rst_timeout", longint'(timeout_o), 0);
        chk_bank("rst_num", numerator_coeffs_o, mdl_num);
        chk_bank("rst_den", denominator_coeffs_o, mdl_den);
        repeat (2) tick();
        reset_i = 1'b1;
        tick();
        chk("ready_after_rst", longint'(sample_ready_o), 1);

        // Impulse through unity gain.
        load_num(65536, 0, 0, 0);
        send(1000, 1'b0);
        drain();
        chk("start_width", longint'(start_max), 1);

        // Reset asserted while waiting on a silent filter.
        send(123, 1'b1);
        repeat (5) tick();
        chk("midwait_ready", longint'(sample_ready_o), 0);
        chk("midwait_valid", longint'(result_valid_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk("arst_valid", longint'(result_valid_o), 0);
        chk("arst_filt_sig", longint'(filt_signal_o), 0);
        chk("arst_start", longint'(filt_start_o), 0);
        chk("arst_ready", longint'(sample_ready_o), 0);
        sb_q.delete(); mdl_hist.delete(); stub_hist.delete();
        for (int k = 0; k < CL; k++) begin mdl_num[k] = 0; mdl_den[k] = 0; sh_num[k] = 0; sh_den[k] = 0; end
        chk_bank("arst_num", numerator_coeffs_o, mdl_num);
        tick();
        reset_i = 1'b1;
        tick();
        chk("ready_after_arst", longint'(sample_ready_o), 1);

        // Backpressure: result must hold, no new start.
        load_num(30000, -20000, 10000, 5000);
        result_ready_i = 1'b0;
        send(int'($signed(SB'($urandom))), 1'b0);
        t = 0;
        while (!result_valid_o && t < 50) begin tick(); t++; end
        chk("bp_valid", longint'(result_valid_o), 1);
        r = result_o;
        sc = start_cnt;
        repeat (10) begin
            tick();
            chk("bp_hold_valid", longint'(result_valid_o), 1);
            chk("bp_stable", longint'(result_o), longint'(r));
            chk("bp_ready", longint'(sample_ready_o), 0);
        end
        chk("bp_no_restart", longint'(start_cnt), longint'(sc));
        result_ready_i = 1'b1;
        drain();

        // Commit issued mid-sample waits for the HOLD->IDLE edge.
        wr(1'b0, 0, 2212, 1'b0);
        wr(1'b0, 1, 6636, 1'b0);
        wr(1'b0, 2, 6636, 1'b0);
        wr(1'b0, 3, 2212, 1'b0);
        chk_bank("shadow_hidden", numerator_coeffs_o, mdl_num);
        result_ready_i = 1'b0;
        send(int'($signed(SB'($urandom))), 1'b0);
        coeff_commit_i = 1'b1;
        tick();
        coeff_commit_i = 1'b0;
        chk("commit_pending", longint'(commit_pending_o), 1);
        t = 0;
        while (!result_valid_o && t < 50) begin
            chk_bank("num_in_wait", numerator_coeffs_o, mdl_num);
            tick();
            t++;
        end
        chk("ac_valid", longint'(result_valid_o), 1);
        repeat (3) begin
            chk_bank("num_in_hold", numerator_coeffs_o, mdl_num);
            chk("pending_in_hold", longint'(commit_pending_o), 1);
            tick();
        end
        result_ready_i = 1'b1;
        tick();
        mdl_num = sh_num;
        chk_bank("num_swapped", numerator_coeffs_o, mdl_num);
        chk("pending_clr", longint'(commit_pending_o), 0);

        // Timeout on a filter that never answers, then recovery.
        send(int'($signed(SB'($urandom))), 1'b1);
        t = 0;
        while (!result_valid_o && t < TO + 20) begin tick(); t++; end
        chk("timeout_latency", longint'(t), TO + 1);
        chk("timeout_flag", longint'(timeout_o), 1);
        drain();
        send(int'($signed(SB'($urandom))), 1'b0);
        drain();
        chk("timeout_sticky", longint'(timeout_o), 1);

        // Denominator bank, then 100 streamed samples.
        wr(1'b1, 0, 100, 1'b0);
        wr(1'b1, 1, -200, 1'b0);
        wr(1'b1, 2, 300, 1'b0);
        wr(1'b1, 3, -400, 1'b1);
        chk_bank("den_loaded", denominator_coeffs_o, mdl_den);
        load_num(2212, 6636, 6636, 2212);
        for (int i = 0; i < 100; i++) begin
            rs = SB'($urandom);
            send(int'(rs), 1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
